// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores against a variable-latency data
// memory (req/ack), MEM/WB pipeline register, upstream freeze and a sticky
// fault flag for misaligned or timed-out accesses.
module mem_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] EX_MEM_ALU_result,
  input  logic [XLEN-1:0] EX_MEM_rs2_data,
  input  logic            EX_MEM_memread,
  input  logic            EX_MEM_memwrite,
  input  logic            EX_MEM_memtoreg,
  input  logic [4:0]      EX_MEM_rd,
  input  logic            EX_MEM_regwrite,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            MEM_stall,
  output logic            MEM_fault,
  output logic [XLEN-1:0] MEM_WB_ALU_result,
  output logic [XLEN-1:0] MEM_WB_mem_data,
  output logic            MEM_WB_memtoreg,
  output logic [4:0]      MEM_WB_rd,
  output logic            MEM_WB_regwrite
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              fault_nxt;
  logic [XLEN-1:0]   wb_alu_nxt, wb_data_nxt;
  logic              wb_m2r_nxt, wb_rw_nxt;
  logic [4:0]        wb_rd_nxt;

  logic access, misaligned, last_wait, complete, commit;

  // Address/data go straight to memory; the freeze keeps them stable.
  assign dmem_we    = EX_MEM_memwrite;
  assign dmem_addr  = EX_MEM_ALU_result;
  assign dmem_wdata = EX_MEM_rs2_data;

  // Access decode, request and stall; reset kills the request immediately.
  always_comb begin
    access     = EX_MEM_memread | EX_MEM_memwrite;
    misaligned = access & (EX_MEM_ALU_result[1:0] != 2'b00);
    last_wait  = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
    dmem_req   = !reset && (((state == IDLE) && access && !misaligned) || (state == WAIT));
    complete   = dmem_req && dmem_ack;
    commit     = complete || ((state == IDLE) && !access);
    MEM_stall  = dmem_req && !dmem_ack && !last_wait;
  end

  // Next state, wait counter, fault and MEM/WB payload (bubble by default).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fault_nxt   = MEM_fault;
    wb_alu_nxt  = '0;
    wb_data_nxt = '0;
    wb_m2r_nxt  = 1'b0;
    wb_rd_nxt   = 5'd0;
    wb_rw_nxt   = 1'b0;

    if (commit) begin
      wb_alu_nxt  = EX_MEM_ALU_result;
      wb_data_nxt = (complete && !EX_MEM_memwrite) ? dmem_rdata : '0;
      wb_m2r_nxt  = EX_MEM_memtoreg;
      wb_rd_nxt   = EX_MEM_rd;
      wb_rw_nxt   = EX_MEM_regwrite;
    end

    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            fault_nxt = 1'b1;
          end else if (!dmem_ack) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (last_wait) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fault_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, fault flag and MEM/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      MEM_fault         <= 1'b0;
      MEM_WB_ALU_result <= '0;
      MEM_WB_mem_data   <= '0;
      MEM_WB_memtoreg   <= 1'b0;
      MEM_WB_rd         <= 5'd0;
      MEM_WB_regwrite   <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      MEM_fault         <= fault_nxt;
      MEM_WB_ALU_result <= wb_alu_nxt;
      MEM_WB_mem_data   <= wb_data_nxt;
      MEM_WB_memtoreg   <= wb_m2r_nxt;
      MEM_WB_rd         <= wb_rd_nxt;
      MEM_WB_regwrite   <= wb_rw_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random transactions checked
// against a transaction-level model of latency, stall, fault and writeback.
module tb_mem_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] EX_MEM_ALU_result, EX_MEM_rs2_data;
  logic            EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg;
  logic [4:0]      EX_MEM_rd;
  logic            EX_MEM_regwrite;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            dmem_ack;
  logic            MEM_stall, MEM_fault;
  logic [XLEN-1:0] MEM_WB_ALU_result, MEM_WB_mem_data;
  logic            MEM_WB_memtoreg;
  logic [4:0]      MEM_WB_rd;
  logic            MEM_WB_regwrite;

  int n_vec = 0;
  int n_err = 0;
  logic exp_fault = 1'b0;

  mem_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rs2_data(EX_MEM_rs2_data),
    .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
    .EX_MEM_memtoreg(EX_MEM_memtoreg), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_regwrite(EX_MEM_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .MEM_stall(MEM_stall), .MEM_fault(MEM_fault),
    .MEM_WB_ALU_result(MEM_WB_ALU_result), .MEM_WB_mem_data(MEM_WB_mem_data),
    .MEM_WB_memtoreg(MEM_WB_memtoreg), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_regwrite(MEM_WB_regwrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] alu, input logic [31:0] data,
                        input logic m2r, input logic [4:0] rd, input logic rw);
    chk({tag, ".alu"}, MEM_WB_ALU_result, alu);
    chk({tag, ".data"}, MEM_WB_mem_data, data);
    chk({tag, ".m2r"}, 32'(MEM_WB_memtoreg), 32'(m2r));
    chk({tag, ".rd"}, 32'(MEM_WB_rd), 32'(rd));
    chk({tag, ".rw"}, 32'(MEM_WB_regwrite), 32'(rw));
    chk({tag, ".fault"}, 32'(MEM_fault), 32'(exp_fault));
  endtask

  // One EX/MEM instruction held until the stage lets it go. lat = cycles
  // from first request to ack (>= TIMEOUT means the memory never answers).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd,
                         input logic rdn, input logic wrn, input logic m2r,
                         input logic [4:0] rdv, input logic rwv,
                         input int lat, input logic [31:0] rdat);
    logic acc, mis, aligned, tout;
    int   n;
    acc     = rdn | wrn;
    mis     = acc && (addr % 4 != 0);
    aligned = acc && !mis;
    tout    = aligned && (lat >= int'(TIMEOUT));
    n       = !aligned ? 1 : (tout ? int'(TIMEOUT) : lat + 1);

    EX_MEM_ALU_result = addr;
    EX_MEM_rs2_data   = wd;
    EX_MEM_memread    = rdn;
    EX_MEM_memwrite   = wrn;
    EX_MEM_memtoreg   = m2r;
    EX_MEM_rd         = rdv;
    EX_MEM_regwrite   = rwv;

    for (int k = 0; k < n; k++) begin
      dmem_ack   = aligned ? (k == lat) : 1'($urandom_range(0, 1));
      dmem_rdata = (aligned && k == lat) ? rdat : $urandom;
      @(negedge clk);
      chk("req", 32'(dmem_req), 32'(aligned));
      chk("stall", 32'(MEM_stall), 32'(aligned && k != n - 1));
      if (aligned) begin
        chk("addr", dmem_addr, addr);
        chk("we", 32'(dmem_we), 32'(wrn));
        chk("wdata", dmem_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (k == n - 1 && (mis || tout)) exp_fault = 1'b1;
      if (k == n - 1 && !mis && !tout)
        chk_wb("wb", addr, (acc && !wrn) ? rdat : 32'h0, m2r, rdv, rwv);
      else
        chk_wb("bubble", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        rdn, wrn;
    int          kind, lat;

    reset = 1'b1;
    EX_MEM_ALU_result = '0; EX_MEM_rs2_data = '0;
    EX_MEM_memread = 1'b0; EX_MEM_memwrite = 1'b0; EX_MEM_memtoreg = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_regwrite = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(dmem_req), 32'h0);
    chk("rst.stall", 32'(MEM_stall), 32'h0);
    chk_wb("rst", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;

    // ALU op, no access
    run_txn(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 0, 32'h0);
    // load, ack same cycle
    run_txn(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 0, 32'hDEADBEEF);
    // load, ack after 3 cycles
    run_txn(32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 3, 32'h0BADF00D);
    // store, ack after 1 cycle
    run_txn(32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1, 32'h55AA55AA);
    // misaligned load
    run_txn(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 0, 32'h11111111);
    // fault persists over a clean access
    run_txn(32'h108, 32'h0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 2, 32'h22222222);
    // both read and write set behaves as a store
    run_txn(32'h10C, 32'h33333333, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1, 0, 32'h44444444);
    // timeout
    run_txn(32'h110, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1, int'(TIMEOUT) + 4, 32'h0);

    // reset in the second wait cycle of a stalled load
    EX_MEM_ALU_result = 32'h300; EX_MEM_memread = 1'b1; EX_MEM_memwrite = 1'b0;
    EX_MEM_memtoreg = 1'b1; EX_MEM_rd = 5'd3; EX_MEM_regwrite = 1'b1;
    dmem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid.req_before", 32'(dmem_req), 32'h1);
    reset = 1'b1;
    #1;
    exp_fault = 1'b0;
    chk("mid.req", 32'(dmem_req), 32'h0);
    chk("mid.stall", 32'(MEM_stall), 32'h0);
    chk_wb("mid", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    EX_MEM_memread = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // a no-access op after reset must see IDLE (no request)
    run_txn(32'h4444, 32'h0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 0, 32'h0);
    run_txn(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2, 32'h76543210);

    // random transactions
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom & 32'hFFFF_FFFC;
      rdn  = (kind == 1 || kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
      wrn  = (kind == 2 || kind == 3) || (kind == 4 && !rdn);
      if (kind == 4) a = a | 32'($urandom_range(1, 3));
      lat  = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                         : $urandom_range(0, 5);
      run_txn(a, $urandom, rdn, wrn, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), lat, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage: consumes the EX/MEM pipeline register outputs and performs word loads and stores against a data memory.
- The data memory uses a variable-latency req/ack handshake.
- Produces the MEM/WB pipeline register.
- Asserts MEM_stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Single clock `clk`; asynchronous active-high `reset`.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT, 16, max cycles spent waiting for dmem_ack before the access is aborted (≥2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- EX_MEM_ALU_result  in  XLEN  ALU result / memory byte address
- EX_MEM_rs2_data  in  XLEN  store data
- EX_MEM_memread  in  1  load
- EX_MEM_memwrite  in  1  store
- EX_MEM_memtoreg  in  1  writeback selects memory data
- EX_MEM_rd  in  5  destination register
- EX_MEM_regwrite  in  1  register write enable
- dmem_req  out  1  access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  XLEN  byte address (= EX_MEM_ALU_result)
- dmem_wdata  out  XLEN  = EX_MEM_rs2_data
- dmem_rdata  in  XLEN  load data, valid in the dmem_ack cycle
- dmem_ack  in  1  access complete this cycle
- MEM_stall  out  1  freeze upstream stages
- MEM_fault  out  1  sticky: misaligned or timed-out access
- MEM_WB_ALU_result  out  XLEN  registered
- MEM_WB_mem_data  out  XLEN  registered load data
- MEM_WB_memtoreg  out  1  registered
- MEM_WB_rd  out  5  registered
- MEM_WB_regwrite  out  1  registered

Behaviour:
- Reset: all MEM_WB_* = 0, MEM_fault = 0, FSM = IDLE, wait counter = 0. Outputs go low immediately; reset mid-access abandons the access, and dmem_req deasserts at once.
- access = EX_MEM_memread | EX_MEM_memwrite. If both are set, treat as a store.
- misaligned = access & (EX_MEM_ALU_result[1:0] != 0).
- dmem_req (combinational) = (IDLE & access & !misaligned) | WAIT.
- dmem_we = EX_MEM_memwrite. dmem_addr and dmem_wdata are driven directly from the inputs, which are held stable by the freeze.
- MEM_stall (combinational) = dmem_req & !dmem_ack & !(WAIT & cnt == TIMEOUT-1).
- IDLE:
  - No access: MEM_WB_* load the inputs at the next edge (MEM_WB_mem_data = 0). One-cycle latency, no stall.
  - Aligned access with dmem_ack the same cycle: complete at the edge and stay in IDLE.
  - Aligned access without dmem_ack: go to WAIT with cnt = 1. MEM_WB gets a bubble (regwrite=0, memtoreg=0, rd=0, data 0).
  - Misaligned: no request and no stall. MEM_fault is set. MEM_WB gets a bubble, so the load does not write back and the store is dropped.
- WAIT:
  - dmem_ack: complete at the edge and go to IDLE, cnt = 0.
  - No ack and cnt == TIMEOUT-1: abort. MEM_fault is set, MEM_WB gets a bubble, go to IDLE. Upstream unfreezes that cycle.
  - Otherwise: cnt++, MEM_WB gets a bubble.
- Complete: MEM_WB_* load the inputs. MEM_WB_mem_data = dmem_rdata for a load, 0 for a store.
- dmem_ack while dmem_req = 0 is ignored.
- MEM_fault stays set until reset.
- Total load latency = ack latency + 1 cycle to MEM_WB.

Test Plan:
- ALU op: ALU_result=0x1234, rd=5, regwrite=1, no access → next edge MEM_WB_ALU_result=0x1234, rd=5, regwrite=1; MEM_stall never 1.
- Load at 0x100, ack same cycle with rdata=0xDEADBEEF → no stall; next edge MEM_WB_mem_data=0xDEADBEEF, memtoreg=1, regwrite=1.
- Load at 0x104, ack 3 cycles after req → MEM_stall high exactly 3 cycles; dmem_req high 4 cycles; MEM_WB regwrite=0 during the wait and 1 on completion; dmem_addr stable throughout.
- Store rs2=0xCAFEF00D to 0x200, ack after 1 cycle → dmem_we=1, dmem_wdata=0xCAFEF00D, 1 stall cycle; MEM_WB_mem_data=0.
- Load at 0x102 → dmem_req never asserted; MEM_fault=1 after the edge; MEM_WB_regwrite=0; MEM_fault persists over later clean accesses.
- Load with no ack, TIMEOUT=16 → stall for 15 cycles then release; MEM_fault=1; MEM_WB bubble. Separately, assert reset in the 2nd wait cycle → dmem_req=0 and all outputs 0 immediately, and the FSM returns to IDLE.
